// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared command/response encodings for the round-robin calculator engine
package calc_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } resp_e;

  // Entry layout at the default 32-bit data / 2-bit tag configuration.
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [1:0]       tag;
  } cmd_entry_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - per-port synchronous command FIFO with registered occupancy count
module calc_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge c_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_rr_engine.sv
// rtl/calc_rr_engine.sv - multi-port calculator: per-port FIFOs, round-robin grant, shared ALU
module calc_rr_engine import calc_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*4-1:0]        req_cmd,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data1,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data2,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DATA_W);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t                 wr_entry   [NUM_PORTS];
  entry_t                 fifo_rdata [NUM_PORTS];
  logic [CW-1:0]          count      [NUM_PORTS];
  logic [PW-1:0]          cand       [NUM_PORTS];
  logic [NUM_PORTS-1:0]   push;
  logic [NUM_PORTS-1:0]   pop;
  logic [NUM_PORTS-1:0]   full;
  logic [NUM_PORTS-1:0]   empty;

  logic [PW-1:0]          rr_ptr;
  logic                   grant_valid;
  logic [PW-1:0]          grant_idx;

  logic                   s1_valid;
  logic [PW-1:0]          s1_port;
  entry_t                 s1_entry;

  logic [DATA_W:0]        sum;
  resp_e                  alu_resp;
  logic [DATA_W-1:0]      alu_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign wr_entry[p]  = {req_cmd[p*4 +: 4], req_data1[p*DATA_W +: DATA_W],
                           req_data2[p*DATA_W +: DATA_W], req_tag[p*TAG_W +: TAG_W]};
    assign push[p]      = (req_cmd[p*4 +: 4] != 4'd0) && !full[p];
    assign pop[p]       = grant_valid && (grant_idx == PW'(p));
    assign req_ready[p] = (count[p] < CW'(DEPTH));
    // Port index visited at search offset p, starting from rr_ptr and wrapping.
    assign cand[p]      = PW'(({1'b0, rr_ptr} + (PW+1)'(p)) % (PW+1)'(NUM_PORTS));

    calc_cmd_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .c_clk (c_clk),
      .reset (reset),
      .push  (push[p]),
      .wdata (wr_entry[p]),
      .pop   (pop[p]),
      .rdata (fifo_rdata[p]),
      .full  (full[p]),
      .empty (empty[p]),
      .count (count[p])
    );
  end

  // Walk offsets from the far end so the nearest non-empty port wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (!empty[cand[i]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[i];
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_port  <= '0;
      s1_entry <= '0;
    end else begin
      if (grant_valid)
        rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      s1_valid <= grant_valid;
      s1_port  <= grant_idx;
      s1_entry <= fifo_rdata[grant_idx];
    end
  end

  always_comb begin
    sum      = {1'b0, s1_entry.data1} + {1'b0, s1_entry.data2};
    alu_resp = ERR;
    alu_data = '0;
    case (s1_entry.cmd)
      4'(ADD): if (!sum[DATA_W]) begin
        alu_resp = OK;
        alu_data = sum[DATA_W-1:0];
      end
      4'(SUB): if (s1_entry.data2 <= s1_entry.data1) begin
        alu_resp = OK;
        alu_data = s1_entry.data1 - s1_entry.data2;
      end
      4'(SHL): begin
        alu_resp = OK;
        alu_data = s1_entry.data1 << s1_entry.data2[SW-1:0];
      end
      4'(SHR): begin
        alu_resp = OK;
        alu_data = s1_entry.data1 >> s1_entry.data2[SW-1:0];
      end
      default: ;
    endcase
  end

  // Only the lane that issued the command carries a result; all others idle at zero.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      if (s1_valid) begin
        out_resp[int'(s1_port)*2 +: 2]           <= alu_resp;
        out_data[int'(s1_port)*DATA_W +: DATA_W] <= alu_data;
        out_tag[int'(s1_port)*TAG_W +: TAG_W]    <= s1_entry.tag;
      end
    end
  end

endmodule

// File: tb/tb_calc_rr_engine.sv
// tb/tb_calc_rr_engine.sv - scoreboard bench for calc_rr_engine with randomized traffic
module tb_calc_rr_engine;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic              c_clk;
  logic              reset;
  logic [NP*4-1:0]   req_cmd;
  logic [NP*DW-1:0]  req_data1;
  logic [NP*DW-1:0]  req_data2;
  logic [NP*TW-1:0]  req_tag;
  logic [NP-1:0]     req_ready;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;

  calc_rr_engine #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(4)) dut (
    .c_clk     (c_clk),
    .reset     (reset),
    .req_cmd   (req_cmd),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .out_resp  (out_resp),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  typedef struct {
    int          port;
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } log_t;

  exp_t sb[$];
  log_t rlog[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [3:0]  c_a [NP];
  logic [31:0] a_a [NP];
  logic [31:0] b_a [NP];
  logic [1:0]  t_a [NP];

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour from the command definitions, using wide arithmetic.
  function automatic exp_t model(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [1:0] t);
    exp_t e;
    logic [63:0] s;
    e.port = p;
    e.tag  = t;
    e.resp = 2'd2;
    e.data = 32'd0;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'h0000_0000_FFFF_FFFF) begin
          e.resp = 2'd1;
          e.data = 32'(s);
        end
      end
      4'd2: if (b <= a) begin
        e.resp = 2'd1;
        e.data = a - b;
      end
      4'd5: begin e.resp = 2'd1; e.data = a << (b % 32); end
      4'd6: begin e.resp = 2'd1; e.data = a >> (b % 32); end
      default: ;
    endcase
    return e;
  endfunction

  int          m_idx;
  int          m_hits;
  logic [1:0]  m_r;
  logic [31:0] m_d;
  logic [1:0]  m_t;
  log_t        m_l;

  always @(negedge c_clk) begin
    if (mon_en) begin
      m_hits = 0;
      for (int p = 0; p < NP; p++) begin
        m_r = out_resp[p*2 +: 2];
        m_d = out_data[p*DW +: DW];
        m_t = out_tag[p*TW +: TW];
        if (m_r != 2'd0) begin
          m_hits++;
          m_l.port = p; m_l.cyc = cyc; m_l.resp = m_r; m_l.data = m_d; m_l.tag = m_t;
          rlog.push_back(m_l);
          m_idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].port == p) begin m_idx = i; break; end
          end
          if (m_idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp port %0d: got resp %0d data %0h tag %0d, required no response",
                     p, m_r, m_d, m_t);
          end else begin
            check($sformatf("resp_p%0d", p), 64'(m_r), 64'(sb[m_idx].resp));
            check($sformatf("data_p%0d", p), 64'(m_d), 64'(sb[m_idx].data));
            check($sformatf("tag_p%0d", p),  64'(m_t), 64'(sb[m_idx].tag));
            sb.delete(m_idx);
          end
        end else begin
          check($sformatf("idle_lane_p%0d", p), {30'd0, m_t, m_d}, 64'd0);
        end
      end
      check("one_lane_per_cycle", 64'(m_hits <= 1), 64'd1);
    end
  end

  task automatic clear_cmds();
    for (int p = 0; p < NP; p++) begin
      c_a[p] = 4'd0; a_a[p] = 32'd0; b_a[p] = 32'd0; t_a[p] = 2'd0;
    end
  endtask

  // Drive one cycle of requests; entries accepted by the handshake go to the scoreboard.
  task automatic step(output int edge_no, output logic [NP-1:0] acc);
    @(posedge c_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      req_cmd[p*4 +: 4]    = c_a[p];
      req_data1[p*DW +: DW] = a_a[p];
      req_data2[p*DW +: DW] = b_a[p];
      req_tag[p*TW +: TW]  = t_a[p];
    end
    edge_no = cyc + 1;
    acc = '0;
    for (int p = 0; p < NP; p++) begin
      if (c_a[p] != 4'd0 && req_ready[p] && reset) begin
        acc[p] = 1'b1;
        sb.push_back(model(p, c_a[p], a_a[p], b_a[p], t_a[p]));
      end
    end
  endtask

  task automatic idle();
    int e;
    logic [NP-1:0] acc;
    clear_cmds();
    step(e, acc);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic rand_op(input int p);
    case ($urandom_range(0, 4))
      0: c_a[p] = 4'd1;
      1: c_a[p] = 4'd2;
      2: c_a[p] = 4'd5;
      3: c_a[p] = 4'd6;
      default: c_a[p] = 4'($urandom_range(1, 15));
    endcase
    a_a[p] = rand_word();
    b_a[p] = rand_word();
    t_a[p] = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 300 && sb.size() > 0; k++) @(posedge c_clk);
    repeat (3) @(posedge c_clk);
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge c_clk);
    #1;
    reset = 1'b0;
    clear_cmds();
    req_cmd = '0;
    @(posedge c_clk);
    #1;
    reset = 1'b1;
    sb.delete();
    rlog.delete();
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  t;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   e_no;
  logic [NP-1:0] acc;
  int   acc1;
  int   drops1;
  int   first4;
  int   n1;

  initial begin
    reset = 1'b0;
    clear_cmds();
    req_cmd = '0; req_data1 = '0; req_data2 = '0; req_tag = '0;
    repeat (3) @(posedge c_clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge c_clk);
    check("reset_out_resp", 64'(out_resp), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_ready", 64'(req_ready), 64'hF);

    // Single add on port 0 with exact latency.
    rlog.delete();
    c_a[0] = 4'd1; a_a[0] = 32'd5; b_a[0] = 32'd3; t_a[0] = 2'd2;
    step(e_no, acc);
    idle();
    drain("single_add_drain");
    check("single_add_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() >= 1) begin
      check("single_add_port", 64'(rlog[0].port), 64'd0);
      check("single_add_resp", 64'(rlog[0].resp), 64'd1);
      check("single_add_data", 64'(rlog[0].data), 64'd8);
      check("single_add_tag", 64'(rlog[0].tag), 64'd2);
      check("single_add_latency", 64'(rlog[0].cyc), 64'(e_no + 2));
    end

    // Known-answer vectors on port 0, back to back.
    vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'd1,  2'd0, 2'd2, 32'd0});
    vecs.push_back('{4'd2, 32'd3,         32'd5,  2'd1, 2'd2, 32'd0});
    vecs.push_back('{4'd2, 32'd5,         32'd5,  2'd3, 2'd1, 32'd0});
    vecs.push_back('{4'd5, 32'd1,         32'h21, 2'd0, 2'd1, 32'd2});
    vecs.push_back('{4'd6, 32'h8000_0000, 32'd31, 2'd1, 2'd1, 32'd1});
    vecs.push_back('{4'hF, 32'd7,         32'd7,  2'd3, 2'd2, 32'd0});
    vecs.push_back('{4'd1, 32'hFFFF_FFFE, 32'd1,  2'd2, 2'd1, 32'hFFFF_FFFF});
    vecs.push_back('{4'd6, 32'hF0,        32'h24, 2'd0, 2'd1, 32'hF});
    rlog.delete();
    foreach (vecs[i]) begin
      c_a[0] = vecs[i].c; a_a[0] = vecs[i].a; b_a[0] = vecs[i].b; t_a[0] = vecs[i].t;
      step(e_no, acc);
    end
    idle();
    drain("vectors_drain");
    check("vectors_count", 64'(rlog.size()), 64'(vecs.size()));
    for (int i = 0; i < vecs.size() && i < rlog.size(); i++) begin
      check($sformatf("kat%0d_resp", i), 64'(rlog[i].resp), 64'(vecs[i].er));
      check($sformatf("kat%0d_data", i), 64'(rlog[i].data), 64'(vecs[i].ed));
      check($sformatf("kat%0d_tag", i),  64'(rlog[i].tag),  64'(vecs[i].t));
    end

    // Fairness: four simultaneous pushes per port must come back in strict rotation.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < NP; p++) rand_op(p);
      step(e_no, acc);
      check("fair_accept", 64'(acc), 64'hF);
    end
    idle();
    drain("fair_drain");
    check("fair_count", 64'(rlog.size()), 64'd16);
    for (int i = 0; i < 16 && i < rlog.size(); i++) begin
      check($sformatf("fair_port%0d", i), 64'(rlog[i].port), 64'(i % NP));
      check($sformatf("fair_cycle%0d", i), 64'(rlog[i].cyc), 64'(rlog[0].cyc + i));
    end

    // Backpressure on port 1 while the other ports stay saturated.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rand_op(0); rand_op(2); rand_op(3);
      step(e_no, acc);
    end
    acc1 = 0; drops1 = 0; first4 = 0;
    for (int k = 0; k < 8; k++) begin
      rand_op(0); rand_op(1); rand_op(2); rand_op(3);
      step(e_no, acc);
      if (acc[1]) acc1++; else drops1++;
      if (k < 4 && acc[1]) first4++;
    end
    idle();
    drain("bp_drain");
    check("bp_first_four_accepted", 64'(first4), 64'd4);
    check("bp_some_dropped", 64'(drops1 > 0), 64'd1);
    n1 = 0;
    foreach (rlog[i]) if (rlog[i].port == 1) n1++;
    check("bp_port1_responses", 64'(n1), 64'(acc1));

    // Reset in the middle of traffic discards everything in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < NP; p++) rand_op(p);
      step(e_no, acc);
    end
    @(posedge c_clk);
    #1;
    reset = 1'b0;
    @(posedge c_clk);
    #1;
    sb.delete();
    rlog.delete();
    @(negedge c_clk);
    check("midreset_out_resp", 64'(out_resp), 64'd0);
    check("midreset_out_data", 64'(out_data), 64'd0);
    check("midreset_out_tag", 64'(out_tag), 64'd0);
    check("midreset_ready", 64'(req_ready), 64'hF);
    @(posedge c_clk);
    #1;
    reset = 1'b1;
    clear_cmds();
    req_cmd = '0;
    repeat (12) @(posedge c_clk);
    check("midreset_no_stale", 64'(rlog.size()), 64'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) rand_op(p);
        else c_a[p] = 4'd0;
      end
      step(e_no, acc);
    end
    idle();
    drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
